// File: rtl/regfile_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_scheduler_pkg
// Description : Shared constants, state encoding and slice helper for the
//               register-file write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_scheduler_pkg;

    // The SRAM macro has a fixed number of write ports.
    localparam int NUM_WR_PORTS = 6;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // LSB position of element idx inside a packed vector of width-bit slices.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_scheduler_wr_port_allocator.sv
`default_nettype none
// ============================================================================
// Module      : wr_port_allocator
// Description : Combinational round-robin allocation of writeback requesters
//               onto the SRAM write ports with same-address suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_port_allocator
    import regfile_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 8,
    parameter int SRAM_INDEX = 7,
    parameter int RRW        = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                     valid_i,
    input  logic [NUM_REQ*SRAM_INDEX-1:0]          addr_i,
    input  logic [RRW-1:0]                         rr_ptr_i,
    output logic [NUM_REQ-1:0]                     grant_o,
    output logic [NUM_WR_PORTS-1:0][RRW-1:0]       port_idx_o,
    output logic [NUM_WR_PORTS-1:0]                port_vld_o,
    output logic [RRW-1:0]                         rr_next_o
);

    localparam int CW = $clog2(NUM_WR_PORTS + 1);

    logic [NUM_WR_PORTS-1:0][SRAM_INDEX-1:0] addr_tab;
    logic [CW-1:0]                           n_grant;
    logic [SRAM_INDEX-1:0]                   cur_addr;
    logic                                    conflict;
    logic                                    miss_found;
    int                                      pos;

    // Scan requesters from rr_ptr; grant in order until ports run out, skipping
    // addresses already claimed this cycle; first skipped requester leads next.
    always_comb begin
        grant_o    = '0;
        port_idx_o = '0;
        port_vld_o = '0;
        rr_next_o  = rr_ptr_i;
        addr_tab   = '0;
        n_grant    = '0;
        cur_addr   = '0;
        conflict   = 1'b0;
        miss_found = 1'b0;
        pos        = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            pos = int'(rr_ptr_i) + j;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cur_addr = addr_i[slice_lsb(pos, SRAM_INDEX) +: SRAM_INDEX];
            conflict = 1'b0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if ((p < int'(n_grant)) && (addr_tab[p] == cur_addr)) begin
                    conflict = 1'b1;
                end
            end
            if (valid_i[pos]) begin
                if ((int'(n_grant) < NUM_WR_PORTS) && !conflict) begin
                    grant_o[pos]        = 1'b1;
                    port_idx_o[n_grant] = RRW'(pos);
                    port_vld_o[n_grant] = 1'b1;
                    addr_tab[n_grant]   = cur_addr;
                    n_grant             = n_grant + CW'(1);
                end else if (!miss_found) begin
                    miss_found = 1'b1;
                    rr_next_o  = RRW'(pos);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_scheduler
// Description : Clears the register-file SRAM after reset, then arbitrates
//               writeback requesters onto its six write ports through one
//               register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int                  SRAM_DEPTH = 128,
    parameter int                  SRAM_INDEX = 7,
    parameter int                  SRAM_WIDTH = 32,
    parameter int                  NUM_REQ    = 8,
    parameter logic [SRAM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*SRAM_INDEX-1:0]      req_addr_i,
    input  logic [NUM_REQ*SRAM_WIDTH-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_WR_PORTS-1:0]            wr_we_o,
    output logic [NUM_WR_PORTS*SRAM_INDEX-1:0] wr_addr_o,
    output logic [NUM_WR_PORTS*SRAM_WIDTH-1:0] wr_data_o,
    output logic                               init_done_o
);

    localparam int RRW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(SRAM_DEPTH + NUM_WR_PORTS);

    state_e                              state_q, state_d;
    logic [CNTW-1:0]                     cnt_q, cnt_d;
    logic [RRW-1:0]                      rr_q, rr_d;
    logic [NUM_WR_PORTS-1:0]             we_q, we_d;
    logic [NUM_WR_PORTS*SRAM_INDEX-1:0]  addr_q, addr_d;
    logic [NUM_WR_PORTS*SRAM_WIDTH-1:0]  data_q, data_d;

    logic [NUM_REQ-1:0]                  grant;
    logic [NUM_WR_PORTS-1:0][RRW-1:0]    port_idx;
    logic [NUM_WR_PORTS-1:0]             port_vld;
    logic [RRW-1:0]                      rr_next;
    logic [31:0]                         entry;

    wr_port_allocator #(
        .NUM_REQ    (NUM_REQ),
        .SRAM_INDEX (SRAM_INDEX),
        .RRW        (RRW)
    ) u_alloc (
        .valid_i    (req_valid_i),
        .addr_i     (req_addr_i),
        .rr_ptr_i   (rr_q),
        .grant_o    (grant),
        .port_idx_o (port_idx),
        .port_vld_o (port_vld),
        .rr_next_o  (rr_next)
    );

    // Next state and next port contents: clearing batches in INIT, granted
    // requests in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        we_d    = '0;
        addr_d  = '0;
        data_d  = '0;
        entry   = '0;
        case (state_q)
            ST_INIT: begin
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    entry = 32'(cnt_q) + 32'(k);
                    we_d[k] = (entry < 32'(SRAM_DEPTH));
                    addr_d[slice_lsb(k, SRAM_INDEX) +: SRAM_INDEX] = entry[SRAM_INDEX-1:0];
                    data_d[slice_lsb(k, SRAM_WIDTH) +: SRAM_WIDTH] = INIT_VALUE;
                end
                if ((32'(cnt_q) + 32'(NUM_WR_PORTS)) >= 32'(SRAM_DEPTH)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNTW'(NUM_WR_PORTS);
                end
            end
            ST_RUN: begin
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    if (port_vld[k]) begin
                        we_d[k] = 1'b1;
                        addr_d[slice_lsb(k, SRAM_INDEX) +: SRAM_INDEX] =
                            req_addr_i[slice_lsb(int'(port_idx[k]), SRAM_INDEX) +: SRAM_INDEX];
                        data_d[slice_lsb(k, SRAM_WIDTH) +: SRAM_WIDTH] =
                            req_data_i[slice_lsb(int'(port_idx[k]), SRAM_WIDTH) +: SRAM_WIDTH];
                    end
                end
                rr_d = rr_next;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, counters and the SRAM-facing register stage; reset drops any
    // write not yet presented to the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wr_we_o     = we_q;
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;
    assign init_done_o = (state_q == ST_RUN);
    assign req_ready_o = (state_q == ST_RUN) ? grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_scheduler
// Description : Directed self-checking bench with an expected-write scoreboard
//               for the register-file write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_scheduler;

    localparam int DEPTH = 128;
    localparam int IW    = 7;
    localparam int DW    = 32;
    localparam int NR    = 8;
    localparam int NP    = 6;

    typedef struct {
        logic [NP-1:0]    we;
        logic [NP*IW-1:0] addr;
        logic [NP*DW-1:0] data;
        logic             strict;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid_i = '0;
    logic [NR*IW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    req_ready_o;
    logic [NP-1:0]    wr_we_o;
    logic [NP*IW-1:0] wr_addr_o;
    logic [NP*DW-1:0] wr_data_o;
    logic             init_done_o;

    logic [IW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    exp_t          exp_q [$];
    int            wcount [DEPTH];
    logic          count_init = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr_i[i*IW +: IW] = a[i];
            req_data_i[i*DW +: DW] = d[i];
        end
    end

    regfile_write_scheduler #(
        .SRAM_DEPTH (DEPTH),
        .SRAM_INDEX (IW),
        .SRAM_WIDTH (DW),
        .NUM_REQ    (NR),
        .INIT_VALUE ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .wr_we_o     (wr_we_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .init_done_o (init_done_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected writes from the listed requesters, port j taking ids[j].
    task automatic push_grants(input int n, input int ids[NP]);
        exp_t e;
        e.we = '0; e.addr = '0; e.data = '0; e.strict = 1'b1;
        for (int j = 0; j < n; j++) begin
            e.we[j]            = 1'b1;
            e.addr[j*IW +: IW] = a[ids[j]];
            e.data[j*DW +: DW] = d[ids[j]];
        end
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.we = '0; e.addr = '0; e.data = '0; e.strict = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_init(input int batch);
        exp_t e;
        int   ent;
        e.we = '0; e.addr = '0; e.data = '0; e.strict = 1'b0;
        for (int k = 0; k < NP; k++) begin
            ent = 6 * batch + k;
            if (ent < DEPTH) begin
                e.we[k]            = 1'b1;
                e.addr[k*IW +: IW] = IW'(ent);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check_ports(input string tag);
        exp_t             e;
        logic [NP*IW-1:0] oa;
        logic [NP*DW-1:0] od;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s sb: observed 0 pending expected >=1 pending", tag);
        end
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oa = wr_addr_o;
            od = wr_data_o;
            if (!e.strict) begin
                for (int k = 0; k < NP; k++) begin
                    if (!e.we[k]) begin
                        oa[k*IW +: IW] = '0;
                        od[k*DW +: DW] = '0;
                    end
                end
            end
            chk({tag, " we"},   256'(wr_we_o), 256'(e.we));
            chk({tag, " addr"}, 256'(oa),      256'(e.addr));
            chk({tag, " data"}, 256'(od),      256'(e.data));
        end
        if (count_init) begin
            for (int k = 0; k < NP; k++) begin
                if (wr_we_o[k]) wcount[wr_addr_o[k*IW +: IW]]++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        for (int i = 0; i < DEPTH; i++) wcount[i] = 0;
        // Requesters already valid during INIT: nothing may be accepted.
        for (int i = 0; i < NR; i++) begin
            a[i] = IW'(10 + i);
            d[i] = DW'(32'h100 + i);
        end
        req_valid_i = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_idle();
        check_ports("cycle0");
        chk("cycle0 init_done", 256'(init_done_o), 256'(1'b0));
        chk("cycle0 ready",     256'(req_ready_o), 256'(8'h00));
        for (int b = 0; b < 22; b++) push_init(b);

        count_init = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            check_ports($sformatf("init%0d", n));
            chk($sformatf("init%0d done", n), 256'(init_done_o), 256'(n == 22));
            if (n < 22) chk($sformatf("init%0d ready", n), 256'(req_ready_o), 256'(8'h00));
        end
        count_init = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (wcount[i] != 1) bad++;
        chk("init coverage", 256'(bad), 256'(0));

        // Over-subscription from rr_ptr=0.
        chk("oversub ready", 256'(req_ready_o), 256'(8'h3F));
        push_grants(6, '{0, 1, 2, 3, 4, 5});
        @(negedge clk);
        check_ports("oversub1");
        req_valid_i = 8'hC0;
        #1;
        chk("oversub2 ready", 256'(req_ready_o), 256'(8'hC0));
        push_grants(2, '{6, 7, 0, 0, 0, 0});

        // Wrap-around from rr_ptr=6.
        @(negedge clk);
        check_ports("oversub2");
        for (int i = 0; i < NR; i++) begin
            a[i] = IW'(20 + i);
            d[i] = DW'(32'h200 + i);
        end
        req_valid_i = 8'hFF;
        #1;
        chk("wrap ready", 256'(req_ready_o), 256'(8'hCF));
        push_grants(6, '{6, 7, 0, 1, 2, 3});

        // rr_ptr=4: 4,5 held; new requester 0 collides with 4, so rr_ptr -> 0.
        @(negedge clk);
        check_ports("wrap");
        a[0] = IW'(24);
        d[0] = 32'h300;
        req_valid_i = 8'h31;
        #1;
        chk("rewind ready", 256'(req_ready_o), 256'(8'h30));
        push_grants(2, '{4, 5, 0, 0, 0, 0});
        @(negedge clk);
        check_ports("rewind");
        req_valid_i = 8'h01;
        #1;
        chk("rewind2 ready", 256'(req_ready_o), 256'(8'h01));
        push_grants(1, '{0, 0, 0, 0, 0, 0});

        // Same-address conflict between 2 and 5 at rr_ptr=0.
        @(negedge clk);
        check_ports("rewind2");
        a[2] = 7'h40; d[2] = 32'hA;
        a[5] = 7'h40; d[5] = 32'hB;
        req_valid_i = 8'h24;
        #1;
        chk("conflict ready", 256'(req_ready_o), 256'(8'h04));
        push_grants(1, '{2, 0, 0, 0, 0, 0});
        @(negedge clk);
        check_ports("conflict");
        req_valid_i = 8'h20;
        #1;
        chk("conflict2 ready", 256'(req_ready_o), 256'(8'h20));
        push_grants(1, '{5, 0, 0, 0, 0, 0});

        // Idle cycle.
        @(negedge clk);
        check_ports("conflict2");
        req_valid_i = 8'h00;
        #1;
        chk("idle ready", 256'(req_ready_o), 256'(8'h00));
        push_idle();

        // rr_ptr must still be 5 after idling.
        @(negedge clk);
        check_ports("idle");
        for (int i = 0; i < NR; i++) begin
            a[i] = IW'(40 + i);
            d[i] = DW'(32'h400 + i);
        end
        req_valid_i = 8'hFF;
        #1;
        chk("post-idle ready", 256'(req_ready_o), 256'(8'hE7));
        push_grants(6, '{5, 6, 7, 0, 1, 2});

        // Six grants made in the same cycle reset is asserted: none may appear.
        @(negedge clk);
        check_ports("post-idle");
        for (int i = 0; i < NR; i++) begin
            if (i != 3 && i != 4) begin
                a[i] = IW'(50 + i);
                d[i] = DW'(32'h500 + i);
            end
        end
        req_valid_i = 8'hFF;
        reset = 1'b1;
        #1;
        chk("flight ready", 256'(req_ready_o), 256'(8'hF9));
        push_idle();

        @(negedge clk);
        check_ports("after reset");
        chk("after reset init_done", 256'(init_done_o), 256'(1'b0));
        chk("after reset ready",     256'(req_ready_o), 256'(8'h00));
        reset = 1'b0;
        req_valid_i = 8'h00;
        push_init(0);
        push_init(1);
        @(negedge clk);
        check_ports("reinit1");
        @(negedge clk);
        check_ports("reinit2");
        chk("sb drained", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
